// File: rtl/t_flip_flop.sv
// Bank of WIDTH independent T flip-flops with complementary outputs.
// Each bit inverts on a rising clock edge when its T input is high; reset is synchronous, active-low.
module t_flip_flop #(
    parameter int unsigned          WIDTH       = 1,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Bits are independent: no carry, just a per-bit XOR with the enable.
    always_comb begin
        q_d = q_q ^ T;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    // Qb is derived from the single register so it can never disagree with Q.
    assign Q  = q_q;
    assign Qb = ~q_q;

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed bench for t_flip_flop: a default 1-bit instance and a 4-bit instance with RESET_VALUE 4'b1010.
module tb_t_flip_flop;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       t_n   = 1'b1;
    logic [3:0] t_w   = 4'b1111;
    logic       q_n;
    logic       qb_n;
    logic [3:0] q_w;
    logic [3:0] qb_w;

    int checks   = 0;
    int failures = 0;

    logic exp_q[$];

    t_flip_flop dut_n (
        .clock (clock),
        .reset (reset),
        .T     (t_n),
        .Q     (q_n),
        .Qb    (qb_n)
    );

    t_flip_flop #(
        .WIDTH       (4),
        .RESET_VALUE (4'b1010)
    ) dut_w (
        .clock (clock),
        .reset (reset),
        .T     (t_w),
        .Q     (q_w),
        .Qb    (qb_w)
    );

    // Clock: 10 time-unit period.
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_n(input string tag, input logic exp);
        check_eq({tag, "_q"},  {63'd0, q_n},  {63'd0, exp});
        check_eq({tag, "_qb"}, {63'd0, qb_n}, {63'd0, ~exp});
    endtask

    task automatic check_w(input string tag, input logic [3:0] exp);
        check_eq({tag, "_qw"},  {60'd0, q_w},  {60'd0, exp});
        check_eq({tag, "_qbw"}, {60'd0, qb_w}, {60'd0, ~exp});
    endtask

    // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset with T held high: T must be ignored.
        reset = 1'b0; t_n = 1'b1; t_w = 4'b1111;
        step(); check_n("rst_e1", 1'b0); check_w("rst_e1", 4'b1010);
        step(); check_n("rst_e2", 1'b0); check_w("rst_e2", 4'b1010);

        // Single toggle then hold.
        reset = 1'b1; t_n = 1'b1; t_w = 4'b0000;
        step(); check_n("tog1", 1'b1); check_w("hold_w", 4'b1010);
        t_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check_n($sformatf("hold%0d", i), 1'b1);
        end

        // Reset mid-operation with T = 1, then release with T = 0.
        reset = 1'b0; t_n = 1'b1;
        step(); check_n("mid_rst", 1'b0); check_w("mid_rst", 4'b1010);
        reset = 1'b1; t_n = 1'b0;
        step(); check_n("post_rst", 1'b0);

        // Continuous toggle from Q = 0.
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        t_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(); check_n($sformatf("cont%0d", i), exp_q.pop_front());
        end

        // T changed between edges must not reach Q before the next edge.
        t_n = 1'b0;
        step(); check_n("tim_pre", 1'b0);
        #2 t_n = 1'b1;
        #1 check_n("tim_mid", 1'b0);
        t_w = 4'b0110;
        #1 check_w("tim_mid", 4'b1010);
        step(); check_n("tim_post", 1'b1); check_w("w_tog", 4'b1100);
        t_n = 1'b0;

        // Wide bank: independent bits, all toggling, then reset back to RESET_VALUE.
        t_w = 4'b1111;
        step(); check_w("w_all", 4'b0011); check_n("w_all_n", 1'b1);
        t_w = 4'b1000;
        step(); check_w("w_msb", 4'b1011);
        reset = 1'b0; t_w = 4'b1111;
        step(); check_w("w_rst", 4'b1010); check_n("w_rst_n", 1'b0);
        reset = 1'b1; t_w = 4'b0001;
        step(); check_w("w_lsb", 4'b1011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t_flip_flop.md
Name: t_flip_flop

Overview:
Synchronous toggle (T) flip-flop bank with complementary outputs.
- On each rising clock edge, every bit whose T input is 1 inverts its stored state; bits with T = 0 hold.
- Used as a divide-by-2 / toggle-state primitive in counters and simple control logic.
- Default instance is a single-bit T flip-flop.

Parameters:
WIDTH, 1, number of independent T flip-flop bits in the bank (legal range 1..64)
RESET_VALUE, 0 (WIDTH bits), value loaded into Q by reset; Qb loads its bitwise complement

Ports:
clock  input  1  single clock; all state changes on its rising edge
reset  input  1  synchronous reset, active-low (0 = reset), sampled on rising edge of clock
T  input  WIDTH  per-bit toggle enable; bit i = 1 toggles Q[i] at the next rising edge
Q  output  WIDTH  stored state, registered
Qb  output  WIDTH  complement of Q, always equal to ~Q

Behaviour:
- Single clock domain; no asynchronous paths. reset affects state only at a rising clock edge.
- Reset:
  - At a rising edge with reset = 0: Q <= RESET_VALUE, Qb <= ~RESET_VALUE, regardless of T.
  - Default: Q = 0, Qb = 1.
  - Reset has priority over T in the same cycle.
- Normal operation at a rising edge with reset = 1, for each bit i:
  - T[i] = 0: Q[i] holds.
  - T[i] = 1: Q[i] <= ~Q[i].
  - Equivalent to Q <= Q ^ T.
- Latency:
  - Q changes exactly one edge after T is sampled. There is no combinational path from T to Q.
  - T changes between edges have no effect until the next rising edge.
- Qb:
  - Qb equals ~Q at all times, including the reset cycle.
  - Implement it either as a combinational inverter of Q or as a second register updated identically. In both cases Q and Qb must never be equal after the first reset edge.
- Before the first reset edge, Q is undefined (X in simulation). The bench must apply reset before checking.
- Reset mid-operation: asserting reset (0) in any cycle discards the toggled state. The next edge with reset = 1 resumes toggling from RESET_VALUE.
- Continuous T = 1: Q toggles every cycle, giving a clock/2 square wave on each such bit.
- Bits are fully independent; there is no carry between bits.
- X on T while reset = 1 propagates X to the affected Q bits; no special handling is required.

Test Plan:
- Reset check: hold reset = 0, T = 1, for 2 edges -> Q = 0, Qb = 1 after each edge; T is ignored during reset.
- Single toggle: reset = 1, T = 1 for one edge from Q = 0 -> Q = 1, Qb = 0; then T = 0 for 3 edges -> Q stays 1, Qb stays 0.
- Continuous toggle: reset = 1, T = 1 for 6 edges starting at Q = 0 -> Q sequence 1,0,1,0,1,0; Qb is always its complement.
- Reset mid-operation: toggle Q to 1, then assert reset = 0 for one edge with T = 1 -> Q = 0, Qb = 1; release reset with T = 0 -> Q remains 0.
- Timing: change T between clock edges -> Q must not change until the next rising edge, with no glitch on Q or Qb.
- WIDTH = 4, RESET_VALUE = 4'b1010: after reset Q = 1010, Qb = 0101; one edge with T = 0110 -> Q = 1100, Qb = 0011.
